dma_io_peripheral: RTL and testbench

//  I/O-device end of the 8237A DMA channel handshake: raises DREQ, answers DACK-qualified IOR_N/IOW_N strobes and signals EOP.

---
 rtl/dma_periph_pkg.sv | 11 +
 rtl/dma_io_peripheral_if.sv | 31 +++
 rtl/dma_periph_fifo.sv | 48 ++++
 rtl/dma_io_peripheral.sv | 123 ++++++++++++
 tb/tb_dma_io_peripheral.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the 8237A-style DMA I/O peripheral.
package dma_periph_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, XFER, TERM} periph_state_t;

    localparam logic DIR_MEM2IO = 1'b0;
    localparam logic DIR_IO2MEM = 1'b1;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/dma_io_peripheral_if.sv
// DMA channel bus plus local valid/ready streams; master = controller/local side, slave = peripheral.
interface dma_io_peripheral_if #(
    parameter int unsigned DW = 8
);
    logic          DREQ;
    logic          DACK;
    logic          IOR_N;
    logic          IOW_N;
    logic [DW-1:0] DB_IN;
    logic [DW-1:0] DB_OUT;
    logic          DB_OE;
    logic          EOP_N_IN;
    logic          EOP_N_OUT;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    modport master (
        output DACK, IOR_N, IOW_N, DB_IN, EOP_N_IN, s_data, s_valid, s_last, m_ready,
        input  DREQ, DB_OUT, DB_OE, EOP_N_OUT, s_ready, m_data, m_valid
    );

    modport slave (
        input  DACK, IOR_N, IOW_N, DB_IN, EOP_N_IN, s_data, s_valid, s_last, m_ready,
        output DREQ, DB_OUT, DB_OE, EOP_N_OUT, s_ready, m_data, m_valid
    );
endinterface

// File: rtl/dma_periph_fifo.sv
// DEPTH x W synchronous FIFO; push-when-full and pop-when-empty are ignored.
module dma_periph_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 9,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) rd_q <= rd_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/dma_io_peripheral.sv
// I/O-device end of an 8237A DMA channel: DREQ/DACK handshake, strobe servicing,
// EOP signalling, and a FIFO bridging the DMA bus to a local stream.
module dma_io_peripheral
    import dma_periph_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic                 dir,
    dma_io_peripheral_if.slave   bus,
    output logic [CNT_W-1:0]     count,
    output logic                 done,
    output logic                 err
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    periph_state_t    state_q, state_d;
    logic             dir_q;
    logic             strb_prev_q;
    logic [DW-1:0]    db_q;
    logic             eop_lat_q;
    logic             en_prev_q;
    logic             dreq_q, dreq_d;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic             f_push, f_pop, f_full, f_empty;
    logic [DW:0]      f_wdata, f_rdata;
    logic [LW-1:0]    f_level;

    logic io2mem, active, strb_n, complete, head_last, term_hit, en_rise, oe;

    dma_periph_fifo #(.DEPTH(DEPTH), .W(DW + 1)) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (f_push),
        .pop   (f_pop),
        .wdata (f_wdata),
        .rdata (f_rdata),
        .level (f_level),
        .full  (f_full),
        .empty (f_empty)
    );

    // Strobe edge detect and FIFO steering; the strobe in use follows the latched direction.
    always_comb begin
        io2mem    = (dir_q == DIR_IO2MEM);
        active    = (state_q == ARMED) || (state_q == XFER);
        strb_n    = io2mem ? bus.IOR_N : bus.IOW_N;
        complete  = active & bus.DACK & ~strb_prev_q & strb_n;
        head_last = f_rdata[DW] & ~f_empty;
        term_hit  = complete & (eop_lat_q | ~bus.EOP_N_IN | (io2mem & head_last));
        en_rise   = enable & ~en_prev_q;
        f_push    = io2mem ? (bus.s_valid & bus.s_ready) : complete;
        f_pop     = io2mem ? complete : (bus.m_valid & bus.m_ready);
        f_wdata   = io2mem ? {bus.s_last, bus.s_data} : {1'b0, db_q};
        oe        = io2mem & active & bus.DACK & ~bus.IOR_N;
    end

    // Next state; disable overrides termination, which overrides handshake moves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)    state_d = ARMED;
            ARMED:   if (bus.DACK)  state_d = XFER;
            XFER:    if (!bus.DACK) state_d = ARMED;
            default: state_d = state_q;
        endcase
        if (term_hit) state_d = TERM;
        if (!enable)  state_d = IDLE;
        dreq_d = ((state_d == ARMED) || (state_d == XFER)) &
                 (io2mem ? (f_level != '0) : (f_level < LW'(DEPTH)));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            dir_q       <= DIR_MEM2IO;
            strb_prev_q <= 1'b1;
            db_q        <= '0;
            eop_lat_q   <= 1'b0;
            en_prev_q   <= 1'b0;
            dreq_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            strb_prev_q <= strb_n;
            db_q        <= bus.DB_IN;
            en_prev_q   <= enable;
            dreq_q      <= dreq_d;
            done_q      <= (state_d == TERM) && (state_q != TERM);
            if (state_q == IDLE) dir_q <= dir;
            // Controller EOP may be pulsed anywhere within the strobe low phase.
            if (complete || !active)                              eop_lat_q <= 1'b0;
            else if (bus.DACK && !strb_n && !bus.EOP_N_IN)        eop_lat_q <= 1'b1;
            if (en_rise) begin
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (complete) begin
                count_q <= count_q + CNT_W'(1);
                if (io2mem ? f_empty : f_full) err_q <= 1'b1;
            end
        end
    end

    assign bus.DREQ      = dreq_q;
    assign bus.DB_OE     = oe;
    assign bus.DB_OUT    = oe ? (f_empty ? {DW{1'b1}} : f_rdata[DW-1:0]) : '0;
    assign bus.EOP_N_OUT = ~(oe & head_last);
    assign bus.s_ready   = io2mem & (f_level < LW'(DEPTH));
    assign bus.m_valid   = ~io2mem & (f_level != '0);
    assign bus.m_data    = f_rdata[DW-1:0];
    assign count         = count_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed self-checking bench for dma_io_peripheral.
module tb_dma_io_peripheral;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        enable;
    logic        dir;
    logic [15:0] count;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    dma_io_peripheral_if #(.DW(8)) bus ();

    dma_io_peripheral #(.DEPTH(16), .DW(8)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .enable (enable),
        .dir    (dir),
        .bus    (bus),
        .count  (count),
        .done   (done),
        .err    (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic iow(input logic [7:0] d, input logic eop);
        bus.DB_IN    = d;
        bus.IOW_N    = 1'b0;
        bus.EOP_N_IN = ~eop;
        @(negedge CLK);
        bus.IOW_N    = 1'b1;
        @(negedge CLK);
        bus.EOP_N_IN = 1'b1;
    endtask

    task automatic spush(input logic [7:0] d, input logic last);
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        @(negedge CLK);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    logic [7:0] rd_exp [3];

    initial begin
        rd_exp[0] = 8'hA5; rd_exp[1] = 8'h5A; rd_exp[2] = 8'hC3;
        RESET = 1'b0; enable = 1'b0; dir = 1'b0;
        bus.DACK = 1'b0; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1; bus.DB_IN = '0;
        bus.EOP_N_IN = 1'b1; bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.m_ready = 1'b0;
        tick(2);
        check("rst_dreq",   32'(bus.DREQ), 32'd0);
        check("rst_oe",     32'(bus.DB_OE), 32'd0);
        check("rst_dbout",  32'(bus.DB_OUT), 32'd0);
        check("rst_eop",    32'(bus.EOP_N_OUT), 32'd1);
        check("rst_count",  32'(count), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        check("rst_mvalid", 32'(bus.m_valid), 32'd0);
        check("rst_sready", 32'(bus.s_ready), 32'd0);
        RESET = 1'b1;
        tick(1);

        // mem->I/O: fill FIFO with 16 bytes
        enable = 1'b1;
        tick(1);
        check("t1_dreq_on", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) iow(8'(i), 1'b0);
        tick(1);
        check("t1_dreq_full", 32'(bus.DREQ), 32'd0);
        check("t1_count",     32'(count), 32'd16);
        check("t1_err",       32'(err), 32'd0);

        // overflow strobe drops 0x77
        iow(8'h77, 1'b0);
        check("t4_err",   32'(err), 32'd1);
        check("t4_count", 32'(count), 32'd17);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t1_mvalid", 32'(bus.m_valid), 32'd1);
            check("t1_mdata",  32'(bus.m_data), 32'(i));
            @(negedge CLK);
        end
        bus.m_ready = 1'b0;
        check("t4_drained", 32'(bus.m_valid), 32'd0);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
        check("t4_err_clr",   32'(err), 32'd0);
        check("t4_count_clr", 32'(count), 32'd0);

        // controller EOP on 4th strobe
        tick(1);
        iow(8'h21, 1'b0);
        iow(8'h22, 1'b0);
        iow(8'h23, 1'b0);
        iow(8'h24, 1'b1);
        check("t3_done",  32'(done), 32'd1);
        check("t3_count", 32'(count), 32'd4);
        tick(1);
        check("t3_done_pulse", 32'(done), 32'd0);
        check("t3_dreq",       32'(bus.DREQ), 32'd0);
        iow(8'h99, 1'b0);
        tick(2);
        check("t3_dreq_hold",  32'(bus.DREQ), 32'd0);
        check("t3_count_hold", 32'(count), 32'd4);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_mdata", 32'(bus.m_data), 32'h21 + 32'(i));
            @(negedge CLK);
        end
        bus.m_ready = 1'b0;
        check("t3_empty", 32'(bus.m_valid), 32'd0);

        // I/O->mem with device EOP on last byte
        enable = 1'b0; dir = 1'b1; bus.DACK = 1'b0;
        tick(2);
        check("t2_idle_dreq", 32'(bus.DREQ), 32'd0);
        spush(8'hA5, 1'b0);
        spush(8'h5A, 1'b0);
        spush(8'hC3, 1'b1);
        enable = 1'b1;
        tick(2);
        check("t2_dreq_on", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.IOR_N = 1'b0;
            #1;
            check("t2_oe",    32'(bus.DB_OE), 32'd1);
            check("t2_dbout", 32'(bus.DB_OUT), 32'(rd_exp[k]));
            check("t2_eop",   32'(bus.EOP_N_OUT), (k == 2) ? 32'd0 : 32'd1);
            @(negedge CLK);
            bus.IOR_N = 1'b1;
            #1;
            check("t2_oe_off", 32'(bus.DB_OE), 32'd0);
            @(negedge CLK);
        end
        check("t2_done",  32'(done), 32'd1);
        check("t2_dreq",  32'(bus.DREQ), 32'd0);
        check("t2_count", 32'(count), 32'd3);
        tick(1);
        check("t2_done_pulse", 32'(done), 32'd0);

        // empty read underflow
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2);
        check("t5_dreq_pre", 32'(bus.DREQ), 32'd0);
        check("t5_err_pre",  32'(err), 32'd0);
        bus.IOR_N = 1'b0;
        #1;
        check("t5_oe",    32'(bus.DB_OE), 32'd1);
        check("t5_dbout", 32'(bus.DB_OUT), 32'hFF);
        @(negedge CLK);
        bus.IOR_N = 1'b1;
        @(negedge CLK);
        check("t5_err",   32'(err), 32'd1);
        check("t5_count", 32'(count), 32'd1);
        tick(1);
        check("t5_dreq",  32'(bus.DREQ), 32'd0);

        // async reset mid strobe
        spush(8'h11, 1'b0);
        tick(2);
        check("t6_dreq_pre", 32'(bus.DREQ), 32'd1);
        bus.IOR_N = 1'b0;
        #1;
        check("t6_oe_pre",    32'(bus.DB_OE), 32'd1);
        check("t6_dbout_pre", 32'(bus.DB_OUT), 32'h11);
        #1;
        RESET = 1'b0;
        #1;
        check("t6_oe",     32'(bus.DB_OE), 32'd0);
        check("t6_dbout",  32'(bus.DB_OUT), 32'd0);
        check("t6_dreq",   32'(bus.DREQ), 32'd0);
        check("t6_count",  32'(count), 32'd0);
        check("t6_err",    32'(err), 32'd0);
        check("t6_eop",    32'(bus.EOP_N_OUT), 32'd1);
        check("t6_sready", 32'(bus.s_ready), 32'd0);
        @(negedge CLK);
        bus.IOR_N = 1'b1; bus.DACK = 1'b0; enable = 1'b0; dir = 1'b0;
        RESET = 1'b1;
        tick(3);
        check("t6_fifo_empty", 32'(bus.m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
